// File: rtl/issueq_pkg.sv
// Shared definitions for the issue-queue select: default sizes, clog2 and the grant-slot record.
package issueq_pkg;

  localparam int NUM_ENTRIES_DEF = 32;
  localparam int ENTRY_LOG_DEF   = 5;
  localparam int MAX_ENTRY_LOG   = 16;

  typedef struct packed {
    logic                     valid;
    logic [MAX_ENTRY_LOG-1:0] entry;
  } grant_slot_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/issueq_prio_pick.sv
// Single lowest-index-first pick over a request vector, built from BW-wide leaves
// whose local one-hots are gated by a second-level block grant.
module issueq_prio_pick #(
  parameter int N   = 32,
  parameter int LOG = 5,
  parameter int BW  = 8
) (
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   onehot_o,
  output logic [LOG-1:0] enc_o,
  output logic           any_o
);

  localparam int NB = N / BW;

  logic [NB-1:0] blk_any;
  logic [NB-1:0] blk_gnt;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_leaf
      logic [BW-1:0] leaf_req;
      logic [BW-1:0] leaf_oh;
      assign leaf_req = req_i[gi*BW +: BW];
      // x & -x isolates the lowest set bit
      assign leaf_oh  = leaf_req & (~leaf_req + BW'(1));
      assign blk_any[gi] = |leaf_req;
      assign onehot_o[gi*BW +: BW] = leaf_oh & {BW{blk_gnt[gi]}};
    end
  endgenerate

  assign blk_gnt = blk_any & (~blk_any + NB'(1));
  assign any_o   = |blk_any;

  always_comb begin
    enc_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_o[i]) enc_o = enc_o | LOG'(i);
    end
  end

endmodule

// File: rtl/issueq_select_rr.sv
// Multi-grant issue-queue select with rotating priority start (ptr) and registered grants.
module issueq_select_rr
  import issueq_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
  parameter int ENTRY_LOG   = clog2(NUM_ENTRIES),
  parameter int NUM_GRANTS  = 2,
  parameter int BLOCK_WIDTH = 8,
  parameter int RR_EN       = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_ENTRIES-1:0]          requestVector_i,
  input  logic                            enable_i,
  input  logic                            flush_i,
  output logic [NUM_GRANTS-1:0]           grantedValid_o,
  output logic [NUM_GRANTS*ENTRY_LOG-1:0] grantedEntry_o,
  output logic [NUM_ENTRIES-1:0]          grantedVector_o
);

  logic [ENTRY_LOG-1:0]            ptr_q, ptr_d;
  logic [NUM_GRANTS-1:0]           valid_q, valid_d;
  logic [NUM_GRANTS*ENTRY_LOG-1:0] entry_q, entry_d;
  logic [NUM_ENTRIES-1:0]          vector_q, vector_d;

  logic [NUM_ENTRIES-1:0]                  therm;
  logic [NUM_GRANTS-1:0][NUM_ENTRIES-1:0]  remain;
  logic [NUM_GRANTS-1:0][NUM_ENTRIES-1:0]  pick_oh;
  grant_slot_t [NUM_GRANTS-1:0]            pick;

  always_comb begin
    therm = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      therm[i] = (i >= int'(ptr_q));
    end
  end

  assign remain[0] = requestVector_i;

  // Each slot searches [ptr, top] first and falls back to the whole vector, so
  // picks walk the circular order without an explicit rotator.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_GRANTS; gi++) begin : g_slot
      logic [NUM_ENTRIES-1:0] m_oh, u_oh;
      logic [ENTRY_LOG-1:0]   m_enc, u_enc;
      logic                   m_any, u_any;

      issueq_prio_pick #(.N(NUM_ENTRIES), .LOG(ENTRY_LOG), .BW(BLOCK_WIDTH)) u_masked (
        .req_i    (remain[gi] & therm),
        .onehot_o (m_oh),
        .enc_o    (m_enc),
        .any_o    (m_any)
      );

      issueq_prio_pick #(.N(NUM_ENTRIES), .LOG(ENTRY_LOG), .BW(BLOCK_WIDTH)) u_unmasked (
        .req_i    (remain[gi]),
        .onehot_o (u_oh),
        .enc_o    (u_enc),
        .any_o    (u_any)
      );

      assign pick_oh[gi]     = m_any ? m_oh : u_oh;
      assign pick[gi].valid  = m_any | u_any;
      assign pick[gi].entry  = MAX_ENTRY_LOG'(m_any ? m_enc : u_enc);

      if (gi < NUM_GRANTS - 1) begin : g_next
        assign remain[gi+1] = remain[gi] & ~pick_oh[gi];
      end

      if (ENTRY_LOG < MAX_ENTRY_LOG) begin : g_hi
        logic unused_entry_hi;
        assign unused_entry_hi = |pick[gi].entry[MAX_ENTRY_LOG-1:ENTRY_LOG];
      end
    end
  endgenerate

  always_comb begin
    valid_d  = '0;
    entry_d  = '0;
    vector_d = '0;
    ptr_d    = ptr_q;
    if (flush_i) begin
      ptr_d = '0;
    end else if (enable_i) begin
      for (int g = 0; g < NUM_GRANTS; g++) begin
        if (pick[g].valid) begin
          valid_d[g]                        = 1'b1;
          entry_d[g*ENTRY_LOG +: ENTRY_LOG] = pick[g].entry[ENTRY_LOG-1:0];
          vector_d                          = vector_d | pick_oh[g];
          // last valid slot wins, giving highest-slot entry + 1
          if (RR_EN != 0) ptr_d = pick[g].entry[ENTRY_LOG-1:0] + ENTRY_LOG'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      valid_q  <= '0;
      entry_q  <= '0;
      vector_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      entry_q  <= entry_d;
      vector_q <= vector_d;
    end
  end

  assign grantedValid_o  = valid_q;
  assign grantedEntry_o  = entry_q;
  assign grantedVector_o = vector_q;

endmodule

// File: tb/tb_issueq_select_rr.sv
// Directed bench for issueq_select_rr: rotating instance plus a fixed-priority instance.
module tb_issueq_select_rr;

  logic        clk;
  logic        reset;
  logic [31:0] req;
  logic        en;
  logic        fl;

  logic [1:0]  gv, fv;
  logic [9:0]  ge, fe;
  logic [31:0] gvec, fvec;

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0] req;
    logic        en;
    logic        fl;
    logic [1:0]  v;
    logic [4:0]  e1;
    logic [4:0]  e0;
    logic [31:0] vec;
  } vec_t;

  issueq_select_rr #(.NUM_ENTRIES(32), .ENTRY_LOG(5), .NUM_GRANTS(2), .BLOCK_WIDTH(8), .RR_EN(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .requestVector_i (req),
    .enable_i        (en),
    .flush_i         (fl),
    .grantedValid_o  (gv),
    .grantedEntry_o  (ge),
    .grantedVector_o (gvec)
  );

  issueq_select_rr #(.NUM_ENTRIES(32), .ENTRY_LOG(5), .NUM_GRANTS(2), .BLOCK_WIDTH(8), .RR_EN(0)) dut_fix (
    .clk             (clk),
    .reset           (reset),
    .requestVector_i (req),
    .enable_i        (en),
    .flush_i         (fl),
    .grantedValid_o  (fv),
    .grantedEntry_o  (fe),
    .grantedVector_o (fvec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req = 32'hFFFF_FFFF;
    en  = 1'b1;
    fl  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      $display("txn reset[%0d] valid=%b entry=%h vector=%h", i, gv, ge, gvec);
      if ({gv, ge, gvec} !== 44'd0) begin
        errors++;
        $display("FAIL reset[%0d] got valid=%b entry=%h vector=%h, expected all zero", i, gv, ge, gvec);
      end
    end
    reset = 1'b1;
    req   = 32'h0;
  endtask

  task automatic test_basic;
    vec_t tv[$];
    tv.push_back(vec_t'{32'h0000_0011, 1'b1, 1'b0, 2'b11, 5'd4,  5'd0,  32'h0000_0011});
    tv.push_back(vec_t'{32'h2000_0000, 1'b1, 1'b0, 2'b01, 5'd0,  5'd29, 32'h2000_0000});
    tv.push_back(vec_t'{32'h8000_0002, 1'b1, 1'b0, 2'b11, 5'd1,  5'd31, 32'h8000_0002});
    tv.push_back(vec_t'{32'h0000_0100, 1'b1, 1'b0, 2'b01, 5'd0,  5'd8,  32'h0000_0100});
    foreach (tv[i]) begin
      req = tv[i].req; en = tv[i].en; fl = tv[i].fl;
      tick();
      checks++;
      $display("txn basic[%0d] req=%h valid=%b entry=%h vector=%h", i, tv[i].req, gv, ge, gvec);
      if ({gv, ge, gvec} !== {tv[i].v, tv[i].e1, tv[i].e0, tv[i].vec}) begin
        errors++;
        $display("FAIL basic[%0d] got valid=%b entry=%h vector=%h, expected valid=%b entry=%h vector=%h",
                 i, gv, ge, gvec, tv[i].v, {tv[i].e1, tv[i].e0}, tv[i].vec);
      end
    end
  endtask

  task automatic test_enable_flush;
    vec_t tv[$];
    tv.push_back(vec_t'{32'hFFFF_FFFF, 1'b0, 1'b0, 2'b00, 5'd0,  5'd0, 32'h0000_0000});
    tv.push_back(vec_t'{32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, 5'd10, 5'd9, 32'h0000_0600});
    tv.push_back(vec_t'{32'hFFFF_FFFF, 1'b1, 1'b1, 2'b00, 5'd0,  5'd0, 32'h0000_0000});
    tv.push_back(vec_t'{32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, 5'd1,  5'd0, 32'h0000_0003});
    tv.push_back(vec_t'{32'h0000_0000, 1'b1, 1'b0, 2'b00, 5'd0,  5'd0, 32'h0000_0000});
    tv.push_back(vec_t'{32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, 5'd3,  5'd2, 32'h0000_000C});
    foreach (tv[i]) begin
      req = tv[i].req; en = tv[i].en; fl = tv[i].fl;
      tick();
      checks++;
      $display("txn en_flush[%0d] req=%h en=%b flush=%b valid=%b entry=%h vector=%h",
               i, tv[i].req, tv[i].en, tv[i].fl, gv, ge, gvec);
      if ({gv, ge, gvec} !== {tv[i].v, tv[i].e1, tv[i].e0, tv[i].vec}) begin
        errors++;
        $display("FAIL en_flush[%0d] got valid=%b entry=%h vector=%h, expected valid=%b entry=%h vector=%h",
                 i, gv, ge, gvec, tv[i].v, {tv[i].e1, tv[i].e0}, tv[i].vec);
      end
    end
  endtask

  task automatic test_wrap;
    vec_t tv[$];
    tv.push_back(vec_t'{32'h4000_0000, 1'b1, 1'b0, 2'b01, 5'd0, 5'd30, 32'h4000_0000});
    tv.push_back(vec_t'{32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, 5'd0, 5'd31, 32'h8000_0001});
    tv.push_back(vec_t'{32'h4000_0000, 1'b1, 1'b0, 2'b01, 5'd0, 5'd30, 32'h4000_0000});
    tv.push_back(vec_t'{32'h8000_0000, 1'b1, 1'b0, 2'b01, 5'd0, 5'd31, 32'h8000_0000});
    tv.push_back(vec_t'{32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, 5'd1, 5'd0,  32'h0000_0003});
    tv.push_back(vec_t'{32'h8000_0001, 1'b1, 1'b0, 2'b11, 5'd0, 5'd31, 32'h8000_0001});
    foreach (tv[i]) begin
      req = tv[i].req; en = tv[i].en; fl = tv[i].fl;
      tick();
      checks++;
      $display("txn wrap[%0d] req=%h valid=%b entry=%h vector=%h", i, tv[i].req, gv, ge, gvec);
      if ({gv, ge, gvec} !== {tv[i].v, tv[i].e1, tv[i].e0, tv[i].vec}) begin
        errors++;
        $display("FAIL wrap[%0d] got valid=%b entry=%h vector=%h, expected valid=%b entry=%h vector=%h",
                 i, gv, ge, gvec, tv[i].v, {tv[i].e1, tv[i].e0}, tv[i].vec);
      end
    end
  endtask

  task automatic test_fixed;
    vec_t tv[$];
    for (int k = 0; k < 4; k++)
      tv.push_back(vec_t'{32'hFFFF_FFFF, 1'b1, 1'b0, 2'b11, 5'd1, 5'd0, 32'h0000_0003});
    tv.push_back(vec_t'{32'h8000_0002, 1'b1, 1'b0, 2'b11, 5'd31, 5'd1, 32'h8000_0002});
    tv.push_back(vec_t'{32'h0000_0100, 1'b1, 1'b0, 2'b01, 5'd0,  5'd8, 32'h0000_0100});
    foreach (tv[i]) begin
      req = tv[i].req; en = tv[i].en; fl = tv[i].fl;
      tick();
      checks++;
      $display("txn fixed[%0d] req=%h valid=%b entry=%h vector=%h", i, tv[i].req, fv, fe, fvec);
      if ({fv, fe, fvec} !== {tv[i].v, tv[i].e1, tv[i].e0, tv[i].vec}) begin
        errors++;
        $display("FAIL fixed[%0d] got valid=%b entry=%h vector=%h, expected valid=%b entry=%h vector=%h",
                 i, fv, fe, fvec, tv[i].v, {tv[i].e1, tv[i].e0}, tv[i].vec);
      end
    end
  endtask

  task automatic test_async_reset;
    req = 32'hFFFF_FFFF; en = 1'b1; fl = 1'b0;
    tick();
    checks++;
    $display("txn async_pre valid=%b", gv);
    if (gv !== 2'b11) begin
      errors++;
      $display("FAIL async_pre got valid=%b, expected 11", gv);
    end
    reset = 1'b0;
    #2;
    checks++;
    $display("txn async_assert valid=%b entry=%h vector=%h fix_valid=%b", gv, ge, gvec, fv);
    if ({gv, ge, gvec, fv, fe, fvec} !== 88'd0) begin
      errors++;
      $display("FAIL async_assert got valid=%b entry=%h vector=%h fix_valid=%b, expected all zero",
               gv, ge, gvec, fv);
    end
    tick();
    checks++;
    if ({gv, ge, gvec} !== 44'd0) begin
      errors++;
      $display("FAIL async_hold got valid=%b entry=%h vector=%h, expected all zero", gv, ge, gvec);
    end
    reset = 1'b1;
    req   = 32'h0000_0001;
    tick();
    checks++;
    $display("txn async_release valid=%b entry=%h vector=%h", gv, ge, gvec);
    if ({gv, ge, gvec} !== {2'b01, 10'd0, 32'h0000_0001}) begin
      errors++;
      $display("FAIL async_release got valid=%b entry=%h vector=%h, expected valid=01 entry=000 vector=00000001",
               gv, ge, gvec);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req    = 32'h0;
    en     = 1'b0;
    fl     = 1'b0;
    test_reset();
    test_basic();
    test_enable_flush();
    test_wrap();
    test_fixed();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
